// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART types, constants and helpers (TX scheduler, baud gen, RX)
// Rev    : 1.0
// ============================================================================
package uart_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_START = 2'd1;
    localparam state_t ST_DATA  = 2'd2;
    localparam state_t ST_STOP  = 2'd3;

    localparam int DATA_BITS = 8;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : uart_rr_arbiter
// Brief  : Combinational round-robin pick, searching upward from pointer+1
// Rev    : 1.0
// ============================================================================
module uart_rr_arbiter
    import uart_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] pointer,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] index
);

    logic          w_hi_any;
    logic          w_lo_any;
    logic [IW-1:0] w_hi_idx;
    logic [IW-1:0] w_lo_idx;

    // Scanning downward leaves the lowest matching index in each candidate;
    // the "above pointer" candidate wins, otherwise wrap to the lowest overall.
    always_comb begin
        w_hi_any = 1'b0;
        w_lo_any = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (IW'(i) > pointer) begin
                    w_hi_any = 1'b1;
                    w_hi_idx = IW'(i);
                end
                w_lo_any = 1'b1;
                w_lo_idx = IW'(i);
            end
        end
    end

    always_comb begin
        grant = '0;
        index = '0;
        if (enable && (w_hi_any || w_lo_any)) begin
            index = w_hi_any ? w_hi_idx : w_lo_idx;
            grant = N'(1) << index;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_scheduler
// Brief  : Round-robin shared 8N1 UART transmitter with internal bit timing
// Rev    : 1.0
// ============================================================================
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200,
    parameter int N_REQ     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [8*N_REQ-1:0]        req_data,
    output logic [N_REQ-1:0]          ack,
    output logic                      busy,
    output logic [clog2(N_REQ)-1:0]   owner,
    output logic                      frame_done,
    output logic                      txd
);

    localparam int              DIV    = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int              OW     = clog2(N_REQ);
    localparam int              CW     = 20;
    localparam logic [CW-1:0]   C_LAST = CW'(DIV - 1);
    localparam logic [2:0]      C_LBIT = 3'(DATA_BITS - 1);

    state_t          r_state;
    logic [CW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic [OW-1:0]   r_ptr;
    logic [OW-1:0]   r_owner;
    logic            r_txd;

    logic [N_REQ-1:0] w_grant;
    logic [OW-1:0]    w_index;
    logic [7:0]       w_byte;
    logic             w_bound;

    uart_rr_arbiter #(
        .N       (N_REQ),
        .IW      (OW)
    ) u_arb (
        .req     (req),
        .pointer (r_ptr),
        .enable  (r_state == ST_IDLE),
        .grant   (w_grant),
        .index   (w_index)
    );

    always_comb begin
        w_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_index == OW'(i)) w_byte = req_data[8*i +: 8];
        end
    end

    assign w_bound    = (r_baud == C_LAST);
    assign ack        = w_grant;
    assign busy       = (r_state != ST_IDLE);
    assign frame_done = (r_state == ST_STOP) && w_bound;
    assign owner      = r_owner;
    assign txd        = r_txd;

    // txd is registered, so each level is scheduled one cycle ahead of the
    // state it belongs to; the start bit shows up the cycle after ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ptr   <= OW'(N_REQ - 1);
            r_owner <= '0;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|w_grant) begin
                        r_state <= ST_START;
                        r_baud  <= '0;
                        r_shift <= w_byte;
                        r_owner <= w_index;
                        r_ptr   <= w_index;
                        r_txd   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_bound) begin
                        r_state <= ST_DATA;
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_txd   <= r_shift[0];
                        r_shift <= r_shift >> 1;
                    end else begin
                        r_baud  <= r_baud + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_bound) begin
                        r_baud <= '0;
                        if (r_bit == C_LBIT) begin
                            r_state <= ST_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_txd   <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    if (w_bound) begin
                        r_state <= ST_IDLE;
                        r_baud  <= '0;
                    end else begin
                        r_baud  <= r_baud + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire
